// File: rtl/number_loader_pkg.sv
// number_loader_pkg: shared definitions for the number loader block.
//   BYTE_W        - width of one assembled byte
//   BYTES_DEFAULT - default number of bytes assembled
//   state_t       - loader FSM encoding (EMPTY / FILL / FULL)
//   SEG_TABLE     - active-low seven-segment patterns, segments g..a, for hex 0..F
package number_loader_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BYTES_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex2digit_hex.sv
// hex2digit_hex: combinational hex nibble to seven-segment pattern decoder.
//   i_hex - nibble to display
//   o_seg - segment pattern, bit order g..a; INVERT=1 gives active-low
//           patterns, INVERT=0 gives their bitwise inverse (active-high)
module hex2digit_hex
  import number_loader_pkg::*;
#(
  parameter int unsigned INVERT = 1
) (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_TABLE[i_hex];
    if (INVERT == 0) begin
      o_seg = ~SEG_TABLE[i_hex];
    end
  end

endmodule

// File: rtl/number_loader.sv
// number_loader: assembles a BYTES-byte number one switch byte at a time.
//   clk           - system clock, rising edge
//   reset         - synchronous active-high reset
//   sw            - byte value to write
//   btn_flg_load  - single-cycle pulse, writes sw into the next byte
//   btn_flg_clear - single-cycle pulse, discards the number (wins over load)
//   number        - assembled number, byte i at [i*8+7:i*8], unwritten bytes 0
//   number_valid  - high while all BYTES bytes are written
//   load_done     - one-cycle pulse when the final byte is written
//   leds          - last byte written
//   digs          - two seven-segment digits showing the written-byte count
module number_loader
  import number_loader_pkg::*;
#(
  parameter int unsigned BYTES  = BYTES_DEFAULT,
  parameter int unsigned INVERT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BYTE_W-1:0]       sw,
  input  logic                    btn_flg_load,
  input  logic                    btn_flg_clear,
  output logic [BYTES*BYTE_W-1:0] number,
  output logic                    number_valid,
  output logic                    load_done,
  output logic [BYTE_W-1:0]       leds,
  output logic [13:0]             digs
);

  localparam logic [5:0] LAST_IDX = 6'(BYTES - 1);

  state_t                    r_state, w_state_d;
  logic [5:0]                r_count, w_count_d;
  logic [BYTES*BYTE_W-1:0]   r_number, w_number_d;
  logic [BYTE_W-1:0]         r_leds, w_leds_d;
  logic                      r_valid, w_valid_d;
  logic                      r_done, w_done_d;

  logic                      w_load;
  logic [BYTES-1:0]          w_byte_en;

  // Loads are only accepted while there is room; clear always wins.
  assign w_load = btn_flg_load && !btn_flg_clear && (r_state != FULL);

  // One enable per byte, decoded from the current write index.
  always_comb begin
    w_byte_en = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_byte_en[i] = w_load && (r_count == 6'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_count  <= '0;
      r_number <= '0;
      r_leds   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_number <= w_number_d;
      r_leds   <= w_leds_d;
      r_valid  <= w_valid_d;
      r_done   <= w_done_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_number_d = r_number;
    w_leds_d   = r_leds;
    w_valid_d  = r_valid;
    w_done_d   = 1'b0;

    if (btn_flg_clear) begin
      w_state_d  = EMPTY;
      w_count_d  = '0;
      w_number_d = '0;
      w_leds_d   = '0;
      w_valid_d  = 1'b0;
    end else if (w_load) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_byte_en[i]) begin
          w_number_d[i*BYTE_W +: BYTE_W] = sw;
        end
      end
      w_leds_d  = sw;
      w_count_d = r_count + 6'd1;
      if (r_count == LAST_IDX) begin
        w_state_d = FULL;
        w_valid_d = 1'b1;
        w_done_d  = 1'b1;
      end else begin
        w_state_d = FILL;
      end
    end
  end

  assign number       = r_number;
  assign number_valid = r_valid;
  assign load_done    = r_done;
  assign leds         = r_leds;

  hex2digit_hex #(
    .INVERT (INVERT)
  ) u_dig_hi (
    .i_hex ({2'b00, r_count[5:4]}),
    .o_seg (digs[13:7])
  );

  hex2digit_hex #(
    .INVERT (INVERT)
  ) u_dig_lo (
    .i_hex (r_count[3:0]),
    .o_seg (digs[6:0])
  );

endmodule

// File: tb/tb_number_loader.sv
module tb_number_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   sw;
  logic         btn_flg_load;
  logic         btn_flg_clear;
  logic [255:0] number;
  logic         number_valid;
  logic         load_done;
  logic [7:0]   leds;
  logic [13:0]  digs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  number_loader #(
    .BYTES  (32),
    .INVERT (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sw            (sw),
    .btn_flg_load  (btn_flg_load),
    .btn_flg_clear (btn_flg_clear),
    .number        (number),
    .number_valid  (number_valid),
    .load_done     (load_done),
    .leds          (leds),
    .digs          (digs)
  );

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction

  function automatic logic [13:0] digs_for(input int c);
    logic [5:0] cc;
    cc = 6'(c);
    digs_for = {seg({2'b00, cc[5:4]}), seg(cc[3:0])};
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [255:0] e_num, input logic [7:0] e_leds,
                         input int e_cnt, input logic e_valid, input logic e_done);
    chk({name, ".number"}, number, e_num);
    chk({name, ".leds"}, 256'(leds), 256'(e_leds));
    chk({name, ".digs"}, 256'(digs), 256'(digs_for(e_cnt)));
    chk({name, ".valid"}, 256'(number_valid), 256'(e_valid));
    chk({name, ".done"}, 256'(load_done), 256'(e_done));
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic ld, input logic clr, input logic [7:0] v, input logic rst);
    btn_flg_load  = ld;
    btn_flg_clear = clr;
    sw            = v;
    reset         = rst;
    @(posedge clk);
    #1;
    btn_flg_load  = 1'b0;
    btn_flg_clear = 1'b0;
    reset         = 1'b0;
  endtask

  typedef struct {
    logic        ld;
    logic        clr;
    logic [7:0]  v;
    logic [31:0] e_num;
    logic [7:0]  e_leds;
    int          e_cnt;
    logic        e_valid;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [255:0] exp_num;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 32'h000000A5, 8'hA5, 1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h3C, 32'h00003CA5, 8'h3C, 2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'hFF, 32'h00FF3CA5, 8'hFF, 3, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h11, 32'h00FF3CA5, 8'hFF, 3, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h22, 32'h00000000, 8'h00, 0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h01, 32'h00000001, 8'h01, 1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h99, 32'h00000000, 8'h00, 0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h5A, 32'h0000005A, 8'h5A, 1, 1'b0};

    btn_flg_load  = 1'b0;
    btn_flg_clear = 1'b0;
    sw            = 8'h00;
    reset         = 1'b1;
    cyc(1'b1, 1'b1, 8'hEE, 1'b1);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    chk_all("reset", 256'h0, 8'h00, 0, 1'b0, 1'b0);

    // Table-driven basic loads, idle and clears.
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].ld, vecs[i].clr, vecs[i].v, 1'b0);
      chk_all($sformatf("vec%0d", i), 256'(vecs[i].e_num), vecs[i].e_leds, vecs[i].e_cnt,
              vecs[i].e_valid, 1'b0);
    end

    // Full fill with sw = index after reset.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    exp_num = '0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      exp_num[i*8 +: 8] = 8'(i);
      if (i < 31) begin
        chk($sformatf("fill%0d.done", i), 256'(load_done), 256'(0));
        chk($sformatf("fill%0d.valid", i), 256'(number_valid), 256'(0));
      end
    end
    chk_all("fill32", exp_num, 8'h1F, 32, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("fill32_after", exp_num, 8'h1F, 32, 1'b1, 1'b0);

    // Load while FULL is ignored.
    cyc(1'b1, 1'b0, 8'h77, 1'b0);
    chk_all("full_load", exp_num, 8'h1F, 32, 1'b1, 1'b0);

    // Clear while FULL, then one load.
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk_all("full_clear", 256'h0, 8'h00, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h42, 1'b0);
    chk_all("after_clear_load", 256'h42, 8'h42, 1, 1'b0, 1'b0);

    // Load and clear together at count 5.
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    chk("cnt5.digs", 256'(digs), 256'(digs_for(5)));
    chk("cnt5.number", number, 256'h00000000C4C3C2C1C0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    chk_all("ld_clr", 256'h0, 8'h00, 0, 1'b0, 1'b0);

    // Reset at count 31 aborts the fill without load_done.
    for (int i = 0; i < 31; i++) cyc(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("cnt31.digs", 256'(digs), 256'(digs_for(31)));
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    chk_all("mid_reset", 256'h0, 8'h00, 0, 1'b0, 1'b0);
    exp_num = '0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
      exp_num[i*8 +: 8] = 8'(8'h80 + i);
      if (i < 31) chk($sformatf("refill%0d.done", i), 256'(load_done), 256'(0));
    end
    chk_all("refill32", exp_num, 8'h9F, 32, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
